// File: rtl/lzs_src_ctrl.sv
// Per-job source sequencer between the 64-bit source FIFO, the 64->16
// halfword unpacker and the LZS decoder core. Admits one job at a time,
// bounds FIFO pops to the job's word count, masks out-of-range halfwords,
// drains unread words after an early decoder finish, and resets the
// unpacker between jobs.
module lzs_src_ctrl #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             job_done,
  output logic             job_err,
  input  logic             m_src_empty,
  output logic             src_getn,
  output logic             u_src_empty,
  input  logic             u_src_getn,
  output logic             u_busy,
  output logic             u_rst,
  input  logic             die,
  output logic             d_die,
  input  logic             dec_busy,
  input  logic             dec_done
);

  localparam int unsigned WD_W = LEN_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [LEN_W-1:0] hw_left, hw_init;
  logic [WD_W-1:0]  wd_need, wd_init, pops, pops_nx;
  logic             done_seen;
  logic             drain_getn;
  logic             done_q, err_q, u_rst_q;
  logic             words_done, last_hw, pop;

  // Ceilings are floor plus a remainder bit so an all-ones length cannot wrap.
  assign hw_init = {1'b0, job_len[LEN_W-1:1]} + {{(LEN_W-1){1'b0}}, job_len[0]};
  assign wd_init = {1'b0, job_len[LEN_W-1:3]} + {{(WD_W-1){1'b0}}, |job_len[2:0]};

  assign words_done = (pops == wd_need);
  assign last_hw    = (hw_left == LEN_W'(1));
  assign pops_nx    = pops + {{(WD_W-1){1'b0}}, pop};

  assign job_ready = (state == S_IDLE);
  assign job_done  = done_q;
  assign job_err   = err_q;
  assign u_rst     = u_rst_q;

  // Next state plus the combinational FIFO/unpacker/decoder handshakes.
  always_comb begin
    state_nx    = state;
    src_getn    = 1'b1;
    u_src_empty = 1'b1;
    u_busy      = 1'b1;
    d_die       = 1'b0;
    case (state)
      S_IDLE: begin
        if (job_valid) state_nx = (job_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        u_src_empty = m_src_empty | words_done;
        src_getn    = u_src_getn | words_done | m_src_empty;
        d_die       = die & (hw_left != '0);
        u_busy      = dec_busy | (hw_left == '0) | (last_hw & die);
        if (dec_done || (d_die && last_hw)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        // drain_getn is the registered "words remain" enable; the live empty
        // flag still gates it so a pop never lands on an empty FIFO.
        src_getn = drain_getn | m_src_empty;
        if (words_done) state_nx = S_FLUSH;
      end
      S_FLUSH: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    pop = ~src_getn;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Job counters, done tracking and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_left    <= '0;
      wd_need    <= '0;
      pops       <= '0;
      done_seen  <= 1'b0;
      drain_getn <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      u_rst_q    <= 1'b0;
    end else begin
      done_q     <= (state_nx == S_DONE);
      err_q      <= (state == S_FLUSH) & ~done_seen;
      u_rst_q    <= (state_nx == S_FLUSH);
      drain_getn <= ~((state_nx == S_DRAIN) & (pops_nx != wd_need));
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            hw_left   <= hw_init;
            wd_need   <= wd_init;
            pops      <= '0;
            done_seen <= 1'b0;
          end
        end
        S_RUN: begin
          pops <= pops_nx;
          if (d_die)    hw_left   <= hw_left - LEN_W'(1);
          if (dec_done) done_seen <= 1'b1;
        end
        S_DRAIN: pops <= pops_nx;
        default: ;
      endcase
    end
  end

endmodule
